operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//   Read side of the integer register file: decode-to-execute operand fetch stage.
//   - Drives rs1/rs2 read addresses to the register file and captures rd1/rd2
//     into an output pipeline register, with a valid/ready handshake on both sides.
//   - Forces x0 to zero and bypasses same-cycle writeback data.
//   - Keeps a pending-write scoreboard that stalls RAW and WAW hazards until the
//     producing writeback arrives.
// PARAMETERS
//   XLEN   32  data width of operands and writeback data
//   NREG   32  number of architectural registers
//   AW      5  register address width, = $clog2(NREG)
// PORTS
//   clk         in   1     clock, rising edge
//   reset_n     in   1     asynchronous active-low reset
//   in_valid    in   1     decoded instruction present
//   in_ready    out  1     stage accepts instruction this cycle
//   in_rs1      in   AW    source register 1 index
//   in_rs2      in   AW    source register 2 index
//   in_rd       in   AW    destination register index
//   in_rd_we    in   1     instruction will write in_rd
//   rf_rs1      out  AW    register file read address 1 (combinational = in_rs1)
//   rf_rs2      out  AW    register file read address 2 (combinational = in_rs2)
//   rf_rd1      in   XLEN  register file read data 1 (combinational read)
//   rf_rd2      in   XLEN  register file read data 2
//   wb_we       in   1     writeback strobe; same signals feed the register file write port
//   wb_rd       in   AW    writeback destination
//   wb_data     in   XLEN  writeback data
//   out_valid   out  1     operands valid toward execute
//   out_ready   in   1     execute accepts
//   out_op1     out  XLEN  operand 1
//   out_op2     out  XLEN  operand 2
//   out_rd      out  AW    destination index
//   out_rd_we   out  1     destination write enable
// BEHAVIOUR
//   - Reset (async, reset_n=0): out_valid=0, out_op1=out_op2=0, out_rd=0,
//     out_rd_we=0, pending[NREG-1:0]=0. Whatever is held in the output register is
//     discarded. Operation resumes on the first clk edge after deassertion.
//   - Operand select, for each source s:
//     - s==0 -> 0, regardless of register file contents.
//     - else if wb_we && wb_rd==s -> wb_data (write-through bypass).
//     - else -> rf_rdN.
//   - Hazard terms (each term is false when its index is 0, and a pending bit being
//     cleared this cycle, i.e. wb_we && wb_rd==idx, counts as not pending):
//     - raw = pending[rs1] || pending[rs2]
//     - waw = in_rd_we && pending[rd]
//   - in_ready = (!out_valid || out_ready) && !raw && !waw. Combinational; no
//     dependence on in_valid.
//   - Accept = in_valid && in_ready. On accept, the output register loads the
//     selected operands plus rd and rd_we, and out_valid=1. Latency: 1 cycle.
//   - If out_valid && out_ready && !accept, out_valid goes to 0. If out_valid &&
//     !out_ready, all out_* are held stable.
//   - Scoreboard, per index:
//     - Set on accept when in_rd_we && in_rd!=0.
//     - Clear when wb_we && wb_rd!=0.
//     - Set and clear of the same index in one cycle -> set wins.
//     - wb_we to x0 has no effect on the scoreboard.
//     - Clear of a bit that is not set is harmless (no error).
//   - Full throughput: back-to-back independent instructions are accepted on every
//     cycle while out_ready=1.
// TESTING
//   - Reset mid-stream: out_valid=1, pending[5]=1, then reset_n=0 -> out_valid=0,
//     pending all 0 immediately, without waiting for clk.
//   - x0 forcing: rf_rd1=32'hDEADBEEF with rs1=0 -> out_op1=0 one cycle after accept.
//   - RAW stall: issue rd=3 (we=1), then rs1=3 -> in_ready=0. Drive wb_we=1,
//     wb_rd=3, wb_data=32'h1234 -> accepted in that same cycle with out_op1=32'h1234.
//   - WAW stall: pending[7]=1, incoming rd=7 we=1 -> in_ready=0 until wb to 7;
//     pending[7]=1 after accept.
//   - Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_* stable for
//     5 cycles. out_ready=1 -> a new instruction is loaded on the same edge.
//   - Throughput: 8 independent instructions with out_ready=1 -> 8 accepts in
//     8 consecutive cycles, operands in order.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read with x0 forcing, writeback bypass,
// and a pending-write scoreboard that stalls RAW/WAW hazards.
module operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_n;
  logic [NREG-1:0] pend_eff;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic            raw;
  logic            waw;
  logic            accept;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  // Hazard detection, handshake and next scoreboard; a writeback landing this
  // cycle already counts as resolved, and a same-cycle set overrides its clear.
  always_comb begin
    clr_vec   = '0;
    set_vec   = '0;
    if (wb_we && (wb_rd != '0))
      clr_vec[wb_rd] = 1'b1;
    pend_eff  = pending & ~clr_vec;
    raw       = ((in_rs1 != '0) && pend_eff[in_rs1]) ||
                ((in_rs2 != '0) && pend_eff[in_rs2]);
    waw       = in_rd_we && (in_rd != '0) && pend_eff[in_rd];
    in_ready  = (!out_valid || out_ready) && !raw && !waw;
    accept    = in_valid && in_ready;
    if (accept && in_rd_we && (in_rd != '0))
      set_vec[in_rd] = 1'b1;
    pending_n = pend_eff | set_vec;

    op1_sel = rf_rd1;
    if (in_rs1 == '0)
      op1_sel = '0;
    else if (wb_we && (wb_rd == in_rs1))
      op1_sel = wb_data;

    op2_sel = rf_rd2;
    if (in_rs2 == '0)
      op2_sel = '0;
    else if (wb_we && (wb_rd == in_rs2))
      op2_sel = wb_data;
  end

  // Output pipeline register and scoreboard state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
    end else begin
      pending <= pending_n;
      if (accept) begin
        out_valid <= 1'b1;
        out_op1   <= op1_sel;
        out_op2   <= op2_sel;
        out_rd    <= in_rd;
        out_rd_we <= in_rd_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed hazard/handshake scenarios
// plus a randomized run against a behavioural scoreboard model.
module tb_operand_fetch;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid, in_ready, in_rd_we;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2, wb_data, out_op1, out_op2;
  logic            wb_we, out_valid, out_ready, out_rd_we;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit              m_pend [NREG];
  logic            m_ov;
  logic [XLEN-1:0] m_op1, m_op2;
  logic [AW-1:0]   m_rd;
  logic            m_rd_we;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  function automatic bit busy(input logic [AW-1:0] idx);
    return (idx != 0) && m_pend[idx] && !(wb_we && (wb_rd == idx));
  endfunction

  function automatic bit m_ready();
    return (!m_ov || out_ready) && !busy(in_rs1) && !busy(in_rs2) &&
           !(in_rd_we && busy(in_rd));
  endfunction

  function automatic logic [XLEN-1:0] m_sel(input logic [AW-1:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 0) return '0;
    if (wb_we && (wb_rd == idx)) return wb_data;
    return rf;
  endfunction

  function automatic logic [NREG-1:0] m_pvec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    m_ov = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rd_we = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;
  endtask

  // Advance one clock edge and apply the same edge to the model; returns at posedge+1.
  task automatic cyc();
    bit acc;
    logic [XLEN-1:0] o1, o2;
    acc = in_valid && m_ready();
    o1  = m_sel(in_rs1, rf_rd1);
    o2  = m_sel(in_rs2, rf_rd2);
    @(posedge clk);
    if (wb_we && (wb_rd != 0)) m_pend[wb_rd] = 1'b0;
    if (acc && in_rd_we && (in_rd != 0)) m_pend[in_rd] = 1'b1;
    if (acc) begin
      m_ov = 1'b1; m_op1 = o1; m_op2 = o2; m_rd = in_rd; m_rd_we = in_rd_we;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if ({out_valid, out_op1, out_op2, out_rd, out_rd_we} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%0b op1=%h op2=%h rd=%0d we=%0b, want all 0",
                        out_valid, out_op1, out_op2, out_rd, out_rd_we);
    end
    @(posedge clk);
    #4 reset_n = 1'b1;
    cyc();
    // Mid-stream: hold a result with pending[5] set, then reset asynchronously.
    in_valid = 1'b1; in_rd = 5'd5; in_rd_we = 1'b1; out_ready = 1'b0;
    cyc();
    idle(); out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || dut.pending[5] !== 1'b1) begin
      n_bad++; $display("FAIL midstream_setup: got v=%0b pend5=%0b, want 1 1", out_valid, dut.pending[5]);
    end
    #1 reset_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || dut.pending !== '0) begin
      n_bad++; $display("FAIL midstream_reset: got v=%0b pend=%h, want 0 0", out_valid, dut.pending);
    end
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_x0();
    idle();
    in_valid = 1'b1; in_rs1 = '0; in_rs2 = 5'd2;
    rf_rd1 = 32'hDEADBEEF; rf_rd2 = 32'h0000_0055;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || rf_rs1 !== 5'd0 || rf_rs2 !== 5'd2) begin
      n_bad++; $display("FAIL x0_ready: got rdy=%0b rs1=%0d rs2=%0d, want 1 0 2", in_ready, rf_rs1, rf_rs2);
    end
    cyc();
    idle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h0 || out_op2 !== 32'h55) begin
      n_bad++; $display("FAIL x0_force: got v=%0b op1=%h op2=%h, want 1 0 55", out_valid, out_op1, out_op2);
    end
    cyc();
  endtask

  task automatic test_raw();
    idle();
    in_valid = 1'b1; in_rd = 5'd3; in_rd_we = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2;
    cyc();
    idle();
    in_valid = 1'b1; in_rs1 = 5'd3; rf_rd1 = 32'hAAAA_AAAA;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL raw_stall: got in_ready=%0b, want 0", in_ready);
      end
      cyc();
    end
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL raw_release: got in_ready=%0b, want 1", in_ready);
    end
    cyc();
    idle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h1234 || dut.pending[3] !== 1'b0) begin
      n_bad++; $display("FAIL raw_bypass: got v=%0b op1=%h pend3=%0b, want 1 1234 0",
                        out_valid, out_op1, dut.pending[3]);
    end
    cyc();
  endtask

  task automatic test_waw();
    idle();
    in_valid = 1'b1; in_rd = 5'd7; in_rd_we = 1'b1;
    cyc();
    in_rs1 = 5'd1; in_rs2 = 5'd2; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL waw_stall: got in_ready=%0b, want 0", in_ready);
      end
      cyc();
    end
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL waw_release: got in_ready=%0b, want 1", in_ready);
    end
    cyc();
    idle();
    n_cmp++;
    if (out_rd !== 5'd7 || out_rd_we !== 1'b1 || dut.pending[7] !== 1'b1) begin
      n_bad++; $display("FAIL waw_setwins: got rd=%0d we=%0b pend7=%0b, want 7 1 1",
                        out_rd, out_rd_we, dut.pending[7]);
    end
    wb_we = 1'b1; wb_rd = 5'd7;
    cyc();
    idle();
    n_cmp++;
    if (dut.pending[7] !== 1'b0) begin
      n_bad++; $display("FAIL waw_clear: got pend7=%0b, want 0", dut.pending[7]);
    end
  endtask

  task automatic test_backpressure();
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd4; in_rd = 5'd9;
    rf_rd1 = 32'hA1A1_0001; rf_rd2 = 32'hA2A2_0002;
    cyc();
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd10; in_rd_we = 1'b0;
    rf_rd1 = 32'hB1B1_0001; rf_rd2 = 32'hB2B2_0002;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_ready: got in_ready=%0b, want 0", in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || out_op1 !== 32'hA1A1_0001 || out_op2 !== 32'hA2A2_0002 ||
          out_rd !== 5'd9 || out_rd_we !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold: got v=%0b op1=%h op2=%h rd=%0d, want 1 a1a10001 a2a20002 9",
                          out_valid, out_op1, out_op2, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_resume_ready: got in_ready=%0b, want 1", in_ready);
    end
    cyc();
    idle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_op1 !== 32'hB1B1_0001 || out_op2 !== 32'hB2B2_0002 || out_rd !== 5'd10) begin
      n_bad++; $display("FAIL bp_resume_load: got v=%0b op1=%h op2=%h rd=%0d, want 1 b1b10001 b2b20002 10",
                        out_valid, out_op1, out_op2, out_rd);
    end
    cyc();
  endtask

  task automatic test_throughput();
    idle();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_rs1 = AW'(1 + i); in_rs2 = AW'(8 + i); in_rd = AW'(16 + i); in_rd_we = 1'b1;
      rf_rd1 = 32'h1000_0000 + 32'(i); rf_rd2 = 32'h2000_0000 + 32'(i);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL tput_ready[%0d]: got in_ready=%0b, want 1", i, in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || out_op1 !== 32'h1000_0000 + 32'(i) ||
          out_op2 !== 32'h2000_0000 + 32'(i) || out_rd !== AW'(16 + i)) begin
        n_bad++; $display("FAIL tput_order[%0d]: got v=%0b op1=%h op2=%h rd=%0d", i,
                          out_valid, out_op1, out_op2, out_rd);
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_rs1    = AW'($urandom_range(0, 7));
      in_rs2    = AW'($urandom_range(0, 7));
      in_rd     = AW'($urandom_range(0, 7));
      in_rd_we  = $urandom % 2;
      rf_rd1    = $urandom;
      rf_rd2    = $urandom;
      wb_we     = $urandom % 2;
      wb_rd     = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      #1;
      n_cmp++;
      if (in_ready !== m_ready() || rf_rs1 !== in_rs1 || rf_rs2 !== in_rs2) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got rdy=%0b rs1=%0d rs2=%0d, want %0b %0d %0d",
                          n, in_ready, rf_rs1, rf_rs2, m_ready(), in_rs1, in_rs2);
      end
      cyc();
      n_cmp++;
      if (out_valid !== m_ov || dut.pending !== m_pvec() ||
          (m_ov && {out_op1, out_op2, out_rd, out_rd_we} !== {m_op1, m_op2, m_rd, m_rd_we})) begin
        n_bad++; $display("FAIL rand_out[%0d]: got v=%0b op1=%h op2=%h rd=%0d we=%0b pend=%h, want v=%0b op1=%h op2=%h rd=%0d we=%0b pend=%h",
                          n, out_valid, out_op1, out_op2, out_rd, out_rd_we, dut.pending,
                          m_ov, m_op1, m_op2, m_rd, m_rd_we, m_pvec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_raw();
    test_waw();
    test_backpressure();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
